// File: rtl/reg_file_driver_pkg.sv
// Shared opcode and sequencer state encodings for the register-file driver and its ALU.
package reg_file_driver_pkg;

    localparam int unsigned DataW = 16;
    localparam int unsigned AddrW = 2;

    typedef enum logic [2:0] {
        OpAdd  = 3'b000,
        OpSub  = 3'b001,
        OpAnd  = 3'b010,
        OpOr   = 3'b011,
        OpSlt  = 3'b100,
        OpAddi = 3'b101,
        OpNor  = 3'b110,
        OpNop  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StExec,
        StWrite
    } state_e;

endpackage

// File: rtl/alu_16bit.sv
// Combinational ALU: wrapping two's-complement arithmetic, logic ops and signed compare.
module alu_16bit
    import reg_file_driver_pkg::*;
#(
    parameter int unsigned DATA_W = DataW
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] y,
    output logic              ovf
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              a_neg;
    logic              b_neg;

    assign sum   = a + b;
    assign diff  = a - b;
    assign a_neg = a[DATA_W-1];
    assign b_neg = b[DATA_W-1];

    always_comb begin
        y   = '0;
        ovf = 1'b0;
        unique case (op)
            OpAdd, OpAddi: begin
                y   = sum;
                // Like-signed operands producing an opposite-signed sum.
                ovf = (a_neg == b_neg) && (sum[DATA_W-1] != a_neg);
            end
            OpSub: begin
                y   = diff;
                ovf = (a_neg != b_neg) && (diff[DATA_W-1] != a_neg);
            end
            OpAnd: y = a & b;
            OpOr:  y = a | b;
            OpSlt: y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            OpNor: y = ~(a | b);
            OpNop: y = '0;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/reg_file_driver.sv
// Sequencer that reads two registers, runs one ALU op and writes the result back.
// One command per four cycles: IDLE -> READ -> EXEC -> WRITE.
module reg_file_driver
    import reg_file_driver_pkg::*;
#(
    parameter int unsigned DATA_W = DataW,
    parameter int unsigned ADDR_W = AddrW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rs,
    input  logic [ADDR_W-1:0] cmd_rt,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [ADDR_W-1:0] rr1,
    output logic [ADDR_W-1:0] rr2,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    output logic [ADDR_W-1:0] wr,
    output logic [DATA_W-1:0] wd,
    output logic              regwrite,
    output logic [DATA_W-1:0] result,
    output logic              overflow,
    output logic              done
);

    state_e            state_q;
    alu_op_e           op_q;
    logic [ADDR_W-1:0] rs_q;
    logic [ADDR_W-1:0] rt_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] result_q;
    logic              ovf_q;
    logic              done_q;
    logic [DATA_W-1:0] alu_y;
    logic              alu_ovf;

    alu_16bit #(
        .DATA_W(DATA_W)
    ) u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (alu_y),
        .ovf(alu_ovf)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= OpNop;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        op_q    <= alu_op_e'(cmd_op);
                        rs_q    <= cmd_rs;
                        rt_q    <= cmd_rt;
                        rd_q    <= cmd_rd;
                        imm_q   <= cmd_imm;
                        state_q <= StRead;
                    end
                end
                StRead: begin
                    a_q     <= rd1;
                    b_q     <= (op_q == OpAddi) ? imm_q : rd2;
                    state_q <= StExec;
                end
                StExec: begin
                    // NOP keeps the previous result but still clears overflow.
                    if (op_q != OpNop) begin
                        result_q <= alu_y;
                    end
                    ovf_q   <= alu_ovf;
                    done_q  <= 1'b1;
                    state_q <= StWrite;
                end
                StWrite: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign rr1       = rs_q;
    assign rr2       = rt_q;
    assign wr        = rd_q;
    assign wd        = result_q;
    assign result    = result_q;
    assign overflow  = ovf_q;
    // Reset gates the strobes so an abandoned WRITE cycle neither commits nor completes.
    assign done      = done_q & ~reset;
    assign regwrite  = (state_q == StWrite) & ~reset & (rd_q != '0) & (op_q != OpNop);

endmodule

// File: tb/tb_reg_file_driver.sv
// Scoreboard bench for reg_file_driver with a behavioural 4x16 register file attached.
module tb_reg_file_driver;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_rs;
    logic [1:0]  cmd_rt;
    logic [1:0]  cmd_rd;
    logic [15:0] cmd_imm;
    logic [1:0]  rr1;
    logic [1:0]  rr2;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [1:0]  wr;
    logic [15:0] wd;
    logic        regwrite;
    logic [15:0] result;
    logic        overflow;
    logic        done;

    always #5 clock = ~clock;

    reg_file_driver #(
        .DATA_W(16),
        .ADDR_W(2)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_rs   (cmd_rs),
        .cmd_rt   (cmd_rt),
        .cmd_rd   (cmd_rd),
        .cmd_imm  (cmd_imm),
        .rr1      (rr1),
        .rr2      (rr2),
        .rd1      (rd1),
        .rd2      (rd2),
        .wr       (wr),
        .wd       (wd),
        .regwrite (regwrite),
        .result   (result),
        .overflow (overflow),
        .done     (done)
    );

    // Register file: $0 reads zero, writes land on the falling edge of the gated clock.
    logic [15:0] rf [4] = '{default: 16'h0};
    assign rd1 = (rr1 == 2'd0) ? 16'h0 : rf[rr1];
    assign rd2 = (rr2 == 2'd0) ? 16'h0 : rf[rr2];
    always @(negedge clock) if (regwrite) rf[wr] <= wd;

    typedef struct {
        int          done_cyc;
        bit          we;
        logic [1:0]  wr;
        logic [15:0] res;
        bit          ovf;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mregs [4] = '{default: 16'h0};
    logic [15:0] mres = 16'h0;
    int          cyc = 0;
    int          last_acc = -100;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference semantics with plain integer arithmetic on signed values.
    task automatic model(input logic [2:0] op, input logic [1:0] rs, input logic [1:0] rt,
                         input logic [1:0] rd, input logic [15:0] imm, output exp_t e);
        int sa, sb_v, si, s;
        sa   = $signed(mregs[rs]);
        sb_v = $signed(mregs[rt]);
        si   = $signed(imm);
        e.ovf = 1'b0;
        e.res = mres;
        case (op)
            3'd0: begin s = sa + sb_v; e.res = s[15:0]; e.ovf = (s > 32767) || (s < -32768); end
            3'd1: begin s = sa - sb_v; e.res = s[15:0]; e.ovf = (s > 32767) || (s < -32768); end
            3'd2: e.res = mregs[rs] & mregs[rt];
            3'd3: e.res = mregs[rs] | mregs[rt];
            3'd4: e.res = (sa < sb_v) ? 16'd1 : 16'd0;
            3'd5: begin s = sa + si; e.res = s[15:0]; e.ovf = (s > 32767) || (s < -32768); end
            3'd6: e.res = ~(mregs[rs] | mregs[rt]);
            default: e.res = mres;
        endcase
        e.we = (op != 3'd7) && (rd != 2'd0);
        e.wr = rd;
        mres = e.res;
        if (e.we) mregs[rd] = e.res;
    endtask

    // Offers a command and holds it until accepted; abandon=1/2 resets in EXEC/WRITE.
    task automatic issue(input logic [2:0] op, input logic [1:0] rs, input logic [1:0] rt,
                         input logic [1:0] rd, input logic [15:0] imm, input int abandon);
        int   waited = 0;
        int   acc;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rs    = rs;
        cmd_rt    = rt;
        cmd_rd    = rd;
        cmd_imm   = imm;
        while (!cmd_ready && waited < 20) begin
            @(posedge clock); #1;
            waited++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        acc      = cyc + 1;
        last_acc = acc;
        if (abandon == 0) begin
            model(op, rs, rt, rd, imm, e);
            e.done_cyc = acc + 2;
            sb.push_back(e);
        end
        @(posedge clock); #1;
        if (abandon != 0) begin
            cmd_valid = 1'b0;
            repeat (abandon) begin @(posedge clock); #1; end
            reset    = 1'b1;
            last_acc = -100;
            @(posedge clock); #1;
            reset = 1'b0;
            mres  = 16'h0;
            chk("result_after_reset", int'(result), 0);
            chk("overflow_after_reset", int'(overflow), 0);
        end
    endtask

    task automatic drain();
        int w = 0;
        cmd_valid = 1'b0;
        while (sb.size() != 0 && w < 50) begin
            @(posedge clock); #1;
            w++;
        end
        chk("drain", sb.size(), 0);
        repeat (2) begin @(posedge clock); #1; end
    endtask

    task automatic check_rf();
        for (int i = 1; i < 4; i++) chk($sformatf("rf_r%0d", i), int'(rf[i]), int'(mregs[i]));
    endtask

    // Monitor: pops the scoreboard on each done pulse, polices strobes and readiness.
    always @(negedge clock) begin
        exp_t e;
        bit   busy;
        if (reset) begin
            chk("reset_regwrite", int'(regwrite), 0);
            chk("reset_done", int'(done), 0);
        end else begin
            busy = (cyc >= last_acc) && (cyc <= last_acc + 2);
            chk("cmd_ready", int'(cmd_ready), int'(!busy));
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_latency", cyc, e.done_cyc);
                    chk("result", int'(result), int'(e.res));
                    chk("overflow", int'(overflow), int'(e.ovf));
                    chk("regwrite", int'(regwrite), int'(e.we));
                    if (e.we) begin
                        chk("wr", int'(wr), int'(e.wr));
                        chk("wd", int'(wd), int'(e.res));
                    end
                end
            end else begin
                chk("stray_regwrite", int'(regwrite), 0);
            end
        end
    end

    initial begin
        logic [15:0] imm;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_rs    = 2'd0;
        cmd_rt    = 2'd0;
        cmd_rd    = 2'd0;
        cmd_imm   = 16'h0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_result", int'(result), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_wr", int'(wr), 0);
        chk("rst_wd", int'(wd), 0);
        chk("rst_rr1", int'(rr1), 0);
        chk("rst_rr2", int'(rr2), 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Back-to-back issue keeps cmd_valid high through each busy window.
        issue(3'd5, 2'd0, 2'd0, 2'd1, 16'h0005, 0);
        issue(3'd5, 2'd0, 2'd0, 2'd2, 16'hFFFD, 0);
        issue(3'd0, 2'd1, 2'd2, 2'd3, 16'h0000, 0);
        issue(3'd1, 2'd1, 2'd2, 2'd3, 16'h0000, 0);
        issue(3'd4, 2'd2, 2'd1, 2'd3, 16'h0000, 0);
        issue(3'd5, 2'd0, 2'd0, 2'd1, 16'h7FFF, 0);
        issue(3'd5, 2'd0, 2'd0, 2'd2, 16'h0001, 0);
        issue(3'd0, 2'd1, 2'd2, 2'd3, 16'h0000, 0);
        issue(3'd5, 2'd0, 2'd0, 2'd1, 16'h0005, 0);
        issue(3'd0, 2'd1, 2'd1, 2'd0, 16'h0000, 0);
        issue(3'd7, 2'd1, 2'd2, 2'd3, 16'h0000, 0);
        drain();
        check_rf();
        chk("r3_overflow_sum", int'(rf[3]), 16'h8000);

        issue(3'd5, 2'd0, 2'd0, 2'd3, 16'h1234, 1);
        issue(3'd5, 2'd0, 2'd0, 2'd3, 16'h1234, 2);
        drain();
        check_rf();

        repeat (60) begin
            case ($urandom_range(0, 3))
                0: imm = 16'h7FFF;
                1: imm = 16'h8000;
                default: imm = 16'($urandom);
            endcase
            issue(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), imm, 0);
            if ($urandom_range(0, 2) == 0) begin
                cmd_valid = 1'b0;
                repeat ($urandom_range(1, 4)) begin @(posedge clock); #1; end
            end
        end
        drain();
        check_rf();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
